bin_to_code_pipe: RTL and testbench
===================================

Name: bin_to_code_pipe

Overview:
- Parametrised, registered successor to the combinational binary-to-one-hot decoder.
- Converts a BIN_W-bit index into an OUT_W-bit code. The code style is selected per transaction: one-hot, one-cold, inclusive thermometer or exclusive thermometer.
- Flags out-of-range indices and keeps a sticky OR-accumulator of indices seen.
- Valid/ready on both sides with a skid buffer, so it drops into streaming datapaths, e.g. channel-select or mask generation, without combinational ready paths.

Parameters:
- BIN_W, 4, index width; legal 1..16.
- OUT_W, 16, code width; legal 1..2**BIN_W. Indices >= OUT_W are out of range.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat; registered.
- bin_i  in  BIN_W  binary index.
- mode_i  in  2  code style, sampled with the beat. 00 one-hot, 01 thermometer inclusive, 10 one-cold, 11 thermometer exclusive.
- acc_en_i  in  1  OR this beat's one-hot into the accumulator; sampled with the beat.
- acc_clr_i  in  1  synchronous accumulator clear, independent of the handshake.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts.
- code_o  out  OUT_W  generated code.
- oor_o  out  1  index was >= OUT_W; qualified by out_valid_o.
- acc_o  out  OUT_W  sticky accumulator.

Behaviour:
- Reset (rst_ni low, asynchronous, any time including mid-transfer):
  - out_valid_o=0, code_o=0, oor_o=0, acc_o=0.
  - Skid buffer empty; in_ready_o=1 after release.
  - In-flight beats are discarded.
- Handshake:
  - Input transfer when in_valid_i & in_ready_o at a rising edge. Output transfer when out_valid_o & out_ready_i.
  - out_valid_o, code_o and oor_o must hold stable while out_valid_o=1 & out_ready_i=0.
- Latency and throughput:
  - A beat accepted at edge k appears on the outputs after edge k (1 cycle) when the output register is empty or draining.
  - Full throughput: 1 beat/cycle with out_ready_i held high.
- Storage:
  - Output register plus a 1-entry skid register.
  - in_ready_o = !skid_full, registered.
  - A beat arriving while the output is stalled goes to the skid. in_ready_o falls on the following cycle.
  - When the output drains, skid moves to output and in_ready_o returns to 1 the next cycle.
  - Order is preserved; no beat is dropped or duplicated.
- Code generation, for in-range index b < OUT_W:
  - one-hot: bit b set.
  - therm-incl: bits 0..b set.
  - one-cold: ~one-hot.
  - therm-excl: bits 0..b-1 set, so b=0 gives 0.
- Out of range, b >= OUT_W:
  - oor=1.
  - one-hot gives all 0; one-cold gives all 1; both thermometers saturate to all 1.
  - When OUT_W = 2**BIN_W, oor is constantly 0.
- Arithmetic: shifts and compares are done at width max(BIN_W, clog2(OUT_W)+1). No truncation wrap: an index of 16 with OUT_W=12 must not alias to bit 4.
- Accumulator:
  - On input transfer with acc_en_i=1 and in range: acc |= one-hot(b), regardless of mode_i.
  - Out-of-range beats never modify acc.
  - Update is visible on acc_o the cycle after the edge.
  - acc_clr_i=1 at an edge clears acc. If an accumulating transfer happens at the same edge, the result is only the new beat's bit (clear then set).
  - Clear acts regardless of in_valid_i and stalls.
- Accumulator ordering: acc_o updates at input acceptance, not at output transfer. Beats buffered in the skid are already accumulated.

Decomposition:
- Package bin_code_pkg:
  - Mode encodings MODE_ONEHOT=2'b00, MODE_THERM=2'b01, MODE_ONECOLD=2'b10, MODE_THERM_X=2'b11.
  - clog2 helper function.
  - Parameter legality checks (elaboration-time assertions).
- Sub-module bin_code_gen: purely combinational (bin, mode) -> (code, oor), parametrised BIN_W/OUT_W. The top holds the skid/output registers and the accumulator.

Test Plan (BIN_W=4, OUT_W=12 unless stated):
- Reset: pull rst_ni low with out_valid_o=1 and skid full -> immediately out_valid_o=0, code_o=0, acc_o=0. After release, in_ready_o=1.
- Modes, bin=5, out_ready_i=1 -> next cycle code_o: mode00=0x020, 01=0x03F, 10=0xFDF, 11=0x01F, all with oor_o=0. Also mode11 bin=0 -> 0x000.
- Out of range: bin=13 -> oor_o=1; mode00=0x000, mode01=0xFFF, mode10=0xFFF, mode11=0xFFF. With BIN_W=4, OUT_W=16: bin=15 mode00 -> 0x8000, oor_o=0.
- Backpressure:
  - Hold out_ready_i=0 and drive beats bin=1,2,3 back-to-back -> beat1 held on output, beat2 in skid, in_ready_o=0 from the cycle after beat2, beat3 not accepted.
  - Release out_ready_i -> outputs 0x002, 0x004, 0x008 in order, no gaps once streaming.
- Accumulator: acc_en_i=1 with bins 1,3,3,11,14 -> acc_o=0x80A (14 ignored, oor). Then acc_clr_i with accepted bin=2, acc_en_i=1 -> acc_o=0x004. Then acc_clr_i alone -> 0x000.
- Random streaming (10k beats, random valid/ready/mode) vs a reference model -> exact code/oor sequence, no loss or duplication, and acc_o matches the model every cycle.

Source files
------------

// File: rtl/bin_code_pkg.sv
// Shared definitions for the binary-to-code pipeline: mode encodings,
// width helpers and parameter legality.
package bin_code_pkg;

   // Code style carried with each beat
   typedef enum logic [1:0] {
      MODE_ONEHOT  = 2'b00,
      MODE_THERM   = 2'b01,
      MODE_ONECOLD = 2'b10,
      MODE_THERM_X = 2'b11
   } code_mode_e;

   // Ceiling log2 with a fixed loop bound so it folds at elaboration
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Legal ranges: BIN_W 1..16, OUT_W 1..2**BIN_W
   function automatic bit params_legal(input int bin_w, input int out_w);
      if (bin_w < 1 || bin_w > 16) return 1'b0;
      if (out_w < 1) return 1'b0;
      if (64'(out_w) > (64'd1 << bin_w)) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/bin_code_gen.sv
// Combinational index-to-code generator. The index is widened before any
// compare so indices >= OUT_W never alias onto a valid bit position.
module bin_code_gen
   import bin_code_pkg::*;
#(
   parameter int BIN_W = 4,
   parameter int OUT_W = 16
) (
   input  logic [BIN_W-1:0] bin,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] code,
   output logic [OUT_W-1:0] onehot,
   output logic             oor
);

   if (!params_legal(BIN_W, OUT_W)) begin : g_illegal_params
      $error("bin_code_gen: BIN_W must be 1..16 and OUT_W 1..2**BIN_W");
   end

   // Wide enough to hold both any index and the value OUT_W itself
   localparam int CW = max_int(BIN_W, clog2(OUT_W) + 1);

   logic [CW-1:0]    idx;
   logic [OUT_W-1:0] therm_incl;
   logic [OUT_W-1:0] therm_excl;

   assign idx = CW'(bin);
   assign oor = (idx >= CW'(OUT_W));

   // Per-bit position compares; out-of-range saturation falls out naturally
   always_comb begin
      onehot     = '0;
      therm_incl = '0;
      therm_excl = '0;
      for (int i = 0; i < OUT_W; i++) begin
         onehot[i]     = (idx == CW'(i));
         therm_incl[i] = (CW'(i) <= idx);
         therm_excl[i] = (CW'(i) < idx);
      end
   end

   // Select the requested code style
   always_comb begin
      code = '0;
      case (code_mode_e'(mode))
         MODE_ONEHOT:  code = onehot;
         MODE_THERM:   code = therm_incl;
         MODE_ONECOLD: code = ~onehot;
         MODE_THERM_X: code = therm_excl;
         default:      code = onehot;
      endcase
   end

endmodule

// File: rtl/bin_to_code_pipe.sv
// Registered binary-to-code converter with valid/ready on both sides,
// a one-entry skid buffer and a sticky OR accumulator of indices seen.
//
// Handshake: a beat moves on a rising edge when valid and ready are both
// high on that side. Once out_valid_o is high, out_valid_o/code_o/oor_o
// hold until out_ready_i takes the beat. in_ready_o is a flop output
// (inverse of skid occupancy) so no combinational path runs from
// out_ready_i to in_ready_o.
module bin_to_code_pipe
   import bin_code_pkg::*;
#(
   parameter int BIN_W = 4,
   parameter int OUT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [BIN_W-1:0] bin_i,
   input  logic [1:0]       mode_i,
   input  logic             acc_en_i,
   input  logic             acc_clr_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] code_o,
   output logic             oor_o,
   output logic [OUT_W-1:0] acc_o
);

   logic [OUT_W-1:0] gen_code;
   logic [OUT_W-1:0] gen_onehot;
   logic             gen_oor;
   logic             skid_valid;
   logic [OUT_W-1:0] skid_code;
   logic             skid_oor;
   logic             in_fire;
   logic             out_free;

   bin_code_gen #(
      .BIN_W (BIN_W),
      .OUT_W (OUT_W)
   ) u_gen (
      .bin    (bin_i),
      .mode   (mode_i),
      .code   (gen_code),
      .onehot (gen_onehot),
      .oor    (gen_oor)
   );

   assign in_ready_o = ~skid_valid;
   assign in_fire    = in_valid_i & in_ready_o;
   // Output register can take a new beat this edge (empty or draining)
   assign out_free   = ~out_valid_o | out_ready_i;

   // Output register and skid: skid drains first so order is preserved
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         code_o      <= '0;
         oor_o       <= 1'b0;
         skid_valid  <= 1'b0;
         skid_code   <= '0;
         skid_oor    <= 1'b0;
      end else if (out_free) begin
         if (skid_valid) begin
            out_valid_o <= 1'b1;
            code_o      <= skid_code;
            oor_o       <= skid_oor;
            skid_valid  <= 1'b0;
         end else if (in_fire) begin
            out_valid_o <= 1'b1;
            code_o      <= gen_code;
            oor_o       <= gen_oor;
         end else begin
            out_valid_o <= 1'b0;
         end
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_code  <= gen_code;
         skid_oor   <= gen_oor;
      end
   end

   // Accumulator updates on input acceptance; clear wins, then the new bit lands
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_o <= '0;
      end else if (acc_clr_i) begin
         acc_o <= (in_fire && acc_en_i && !gen_oor) ? gen_onehot : '0;
      end else if (in_fire && acc_en_i && !gen_oor) begin
         acc_o <= acc_o | gen_onehot;
      end
   end

endmodule

// File: tb/tb_bin_to_code_pipe.sv
// Bench for bin_to_code_pipe (BIN_W=4, OUT_W=12) plus a second instance
// with OUT_W=16 for the full-range case.
module tb_bin_to_code_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  bin;
   logic [1:0]  mode;
   logic        acc_en;
   logic        acc_clr;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] code;
   logic        oor;
   logic [11:0] acc;

   logic        in_ready16;
   logic        out_valid16;
   logic [15:0] code16;
   logic        oor16;
   logic [15:0] acc16;

   int          check_cnt = 0;
   int          pass_cnt  = 0;
   int          fail_cnt  = 0;
   int          accepted  = 0;
   logic [12:0] exp_q[$];
   logic [11:0] model_acc = '0;

   bin_to_code_pipe #(.BIN_W(4), .OUT_W(12)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .bin_i       (bin),
      .mode_i      (mode),
      .acc_en_i    (acc_en),
      .acc_clr_i   (acc_clr),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .code_o      (code),
      .oor_o       (oor),
      .acc_o       (acc)
   );

   bin_to_code_pipe #(.BIN_W(4), .OUT_W(16)) u_dut16 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready16),
      .bin_i       (bin),
      .mode_i      (mode),
      .acc_en_i    (acc_en),
      .acc_clr_i   (acc_clr),
      .out_valid_o (out_valid16),
      .out_ready_i (out_ready),
      .code_o      (code16),
      .oor_o       (oor16),
      .acc_o       (acc16)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {oor, code} for OUT_W=12
   function automatic logic [12:0] model(input logic [3:0] b, input logic [1:0] m);
      int          ob;
      logic [11:0] c;
      logic        o;
      ob = int'(b);
      o  = (ob >= 12);
      if (o) begin
         c = (m == 2'b00) ? 12'h000 : 12'hFFF;
      end else begin
         case (m)
            2'b00:   c = 12'(1 << ob);
            2'b01:   c = 12'((2 << ob) - 1);
            2'b10:   c = ~12'(1 << ob);
            default: c = 12'((1 << ob) - 1);
         endcase
      end
      return {o, c};
   endfunction

   // Scoreboard: inputs are stable at the falling edge, so transfers seen
   // here are the ones the next rising edge performs.
   always @(negedge clk) begin
      logic [12:0] e;
      if (!rst_n) begin
         exp_q.delete();
         model_acc = '0;
      end else begin
         check("acc", acc, model_acc);
         if (out_valid && out_ready) begin
            check("q_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("code", code, e[11:0]);
               check("oor", oor, e[12]);
            end
         end
         if (acc_clr) model_acc = '0;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(bin, mode));
            accepted++;
            if (acc_en && bin < 12) model_acc = model_acc | 12'(1 << int'(bin));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the current beat until a rising edge accepts it
   task automatic send(input logic [3:0] b, input logic [1:0] m, input logic ae);
      logic rdy;
      int   n;
      in_valid = 1'b1;
      bin      = b;
      mode     = m;
      acc_en   = ae;
      n        = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 100);
      check("accept_wait", (n < 100), 1);
   endtask

   logic [3:0]  t_bin [10] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd13, 4'd13, 4'd13, 4'd13, 4'd15};
   logic [1:0]  t_mode[10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [11:0] t_code[10] = '{12'h020, 12'h03F, 12'hFDF, 12'h01F, 12'h000,
                               12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000};
   logic        t_oor [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      int cyc;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      bin       = '0;
      mode      = '0;
      acc_en    = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_code", code, 0);
      check("rst_oor", oor, 0);
      check("rst_acc", acc, 0);
      check("rst_acc16", acc16, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      check("rel_in_ready", in_ready, 1);
      check("rel_in_ready16", in_ready16, 1);

      // Code styles and out-of-range handling, back-to-back
      for (int i = 0; i < 10; i++) begin
         send(t_bin[i], t_mode[i], 1'b0);
         check($sformatf("mode_code_%0d", i), code, t_code[i]);
         check($sformatf("mode_oor_%0d", i), oor, t_oor[i]);
         check($sformatf("mode_valid_%0d", i), out_valid, 1);
         if (i == 9) begin
            check("full_range_code16", code16, 16'h8000);
            check("full_range_oor16", oor16, 0);
            check("full_range_valid16", out_valid16, 1);
         end
      end
      in_valid = 1'b0;
      step();
      check("idle_out_valid", out_valid, 0);

      // Backpressure: beat1 held, beat2 in skid, beat3 refused
      out_ready = 1'b0;
      send(4'd1, 2'd0, 1'b0);
      check("bp_b1_code", code, 12'h002);
      check("bp_b1_ready", in_ready, 1);
      send(4'd2, 2'd0, 1'b0);
      check("bp_b2_hold", code, 12'h002);
      check("bp_b2_ready", in_ready, 0);
      bin = 4'd3;
      step();
      check("bp_b3_ready", in_ready, 0);
      check("bp_b3_hold", code, 12'h002);
      check("bp_b3_valid", out_valid, 1);
      step();
      check("bp_b3_hold2", code, 12'h002);
      out_ready = 1'b1;
      step();
      check("bp_drain_code", code, 12'h004);
      check("bp_drain_ready", in_ready, 1);
      step();
      check("bp_b3_code", code, 12'h008);
      check("bp_b3_valid_out", out_valid, 1);
      in_valid = 1'b0;
      step();
      check("bp_empty", out_valid, 0);

      // Accumulator
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      send(4'd1, 2'd2, 1'b1);
      send(4'd3, 2'd0, 1'b1);
      send(4'd3, 2'd1, 1'b1);
      send(4'd11, 2'd3, 1'b1);
      send(4'd14, 2'd0, 1'b1);
      check("acc_sum", acc, 12'h80A);
      acc_clr = 1'b1;
      send(4'd2, 2'd0, 1'b1);
      check("acc_clr_set", acc, 12'h004);
      in_valid = 1'b0;
      step();
      check("acc_clr_only", acc, 12'h000);
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      step();

      // Asynchronous reset with output valid and skid full
      out_ready = 1'b0;
      send(4'd1, 2'd0, 1'b1);
      send(4'd2, 2'd0, 1'b1);
      in_valid = 1'b0;
      check("pre_rst_skid", in_ready, 0);
      check("pre_rst_acc", acc, 12'h006);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_code", code, 0);
      check("mid_rst_oor", oor, 0);
      check("mid_rst_acc", acc, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      check("post_rst_ready", in_ready, 1);
      check("post_rst_valid", out_valid, 0);

      // Random streaming against the scoreboard
      accepted = 0;
      cyc = 0;
      while (accepted < 10000 && cyc < 60000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         bin       = 4'($urandom_range(0, 15));
         mode      = 2'($urandom_range(0, 3));
         acc_en    = 1'($urandom_range(0, 1));
         acc_clr   = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         step();
         cyc++;
      end
      check("random_beats", (accepted >= 10000), 1);
      in_valid  = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", out_valid, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
